phy_rx_vc_manager: RTL and testbench
====================================

// Module: phy_rx_vc_manager
// PURPOSE
//  Parametrised receive-side PHY manager: accepts decoded flits from the PHY, each tagged with a
//  virtual-channel (VC) id, into per-VC circular FIFOs. It presents per-VC backpressure to the PHY and
//  round-robin arbitrates buffered flits toward the switch with a valid/ready handshake. Sits between
//  the PHY decoder and a switch input port. Generalises the single-channel rx manager to NUM_VC channels.
// PARAMETERS
//  FLIT_W   32  flit payload width in bits
//  NUM_VC   2   number of virtual channels (>=1)
//  DEPTH    4   FIFO entries per VC (power of 2, >=2)
//  VC_W     (NUM_VC>1 ? $clog2(NUM_VC) : 1)  derived; VC id width, do not override
// PORTS
//  CLK            in   1       clock; all state on rising edge
//  nRST           in   1       asynchronous active-low reset
//  phy_valid      in   1       PHY presents a flit this cycle
//  phy_flit       in   FLIT_W  flit payload from PHY
//  phy_vc         in   VC_W    target VC of phy_flit
//  buffer_full    out  NUM_VC  per-VC full flag to PHY
//  sw_data_ready  out  1       flit valid toward switch
//  sw_flit        out  FLIT_W  flit toward switch
//  sw_vc          out  VC_W    VC of sw_flit
//  sw_ready       in   1       switch accepts sw_flit this cycle
//  overflow_err   out  1       sticky: a flit was dropped on a full VC
//  parity_in      in   1       (PHY_RX_PARITY_EN only) even parity over phy_flit
//  parity_err     out  1       (PHY_RX_PARITY_EN only) sticky: a parity mismatch was seen
// BEHAVIOUR
//  Reset: one clock, CLK; reset asynchronous, active-low on nRST. While nRST=0: all FIFOs empty,
//   pointers 0, RR pointer 0, buffer_full=0, sw_data_ready=0, sw_vc=0, overflow_err=0, parity_err=0.
//   sw_flit is don't-care while sw_data_ready=0. Reset mid-transfer discards all buffered flits.
//  FIFOs: per-VC storage with rd/wr pointers carrying one extra wrap bit; count = wr-rd, range 0..DEPTH.
//   buffer_full[v] = (count[v]==DEPTH), taken from registered state (no combinational path from inputs).
//  Write: phy_valid=1 pushes phy_flit into VC phy_vc at the clock edge.
//   - VC full and not popped this cycle -> flit dropped, overflow_err<=1 (sticky until reset).
//   - VC full and popped this cycle -> write accepted (slot freed by pop), no error.
//   - phy_vc >= NUM_VC -> flit dropped, overflow_err<=1.
//  Latency: flit written at edge N is eligible at the output from cycle N+1 (no same-cycle bypass).
//  Output arbitration: round-robin over non-empty VCs starting at rr_ptr.
//   - sw_data_ready=1 whenever any VC is non-empty; sw_flit/sw_vc = head of the granted VC.
//   - Grant locks while sw_data_ready=1 && sw_ready=0: sw_flit and sw_vc stay stable until accepted.
//   - On sw_data_ready && sw_ready: pop the granted VC, rr_ptr <= granted VC + 1 (mod NUM_VC).
//   - Simultaneous push and pop on the same VC: count unchanged, FIFO order preserved.
//  Ordering: per-VC FIFO order is strict; no ordering guarantee across VCs.
//  Empty: all VCs empty -> sw_data_ready=0, rr_ptr holds.
// CONFIGURATION
//  PHY_RX_PARITY_EN defined: parity_in/parity_err ports exist. An accepted write requires
//   parity_in == ^phy_flit; on mismatch the flit is dropped (no FIFO change), parity_err<=1 sticky.
//   A flit with bad parity aimed at a full VC sets both error flags.
//  PHY_RX_PARITY_EN undefined: ports absent; every flit on phy_valid is written per the rules above.
// TESTING
//  1 Reset: nRST=0 mid-stream with 3 flits buffered -> outputs at reset values, buffered flits lost, sw_data_ready=0.
//  2 Single VC: push 0xA5A5_0001..0004 on VC0 with sw_ready=0 -> buffer_full=2'b01 after 4th edge;
//    5th push 0xDEAD_BEEF -> dropped, overflow_err=1; then sw_ready=1 -> 0001..0004 out in order.
//  3 Full+pop: VC0 full, sw_ready=1 popping VC0 and push 0x1234_5678 to VC0 in same cycle -> accepted,
//    overflow_err stays 0, buffer_full[0] stays 1.
//  4 Round-robin: VC0={0x10,0x11}, VC1={0x20,0x21}, sw_ready=1 -> output order 0x10,0x20,0x11,0x21,
//    sw_vc 0,1,0,1; then sw_data_ready=0.
//  5 Stall: sw_ready=0 for 5 cycles with VC1 head 0x20 granted while VC0 fills -> sw_flit=0x20, sw_vc=1 stable.
//  6 (PHY_RX_PARITY_EN) push 0x0000_0001 with parity_in=0 -> dropped, parity_err=1, FIFO count unchanged;
//    same flit with parity_in=1 -> accepted.

Source files
------------

// File: rtl/phy_rx_vc_manager.sv
// Receive-side PHY manager: per-VC circular FIFOs with round-robin, grant-locked output to the switch.
// Optional PHY_RX_PARITY_EN adds even-parity checking of incoming flits (parity_in/parity_err).
module phy_rx_vc_manager #(
    parameter int FLIT_W = 32,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 4,
    parameter int VC_W   = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              phy_valid,
    input  logic [FLIT_W-1:0] phy_flit,
    input  logic [VC_W-1:0]   phy_vc,
    output logic [NUM_VC-1:0] buffer_full,
    output logic              sw_data_ready,
    output logic [FLIT_W-1:0] sw_flit,
    output logic [VC_W-1:0]   sw_vc,
    input  logic              sw_ready,
    output logic              overflow_err
`ifdef PHY_RX_PARITY_EN
    ,
    input  logic              parity_in,
    output logic              parity_err
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [FLIT_W-1:0] mem [NUM_VC][DEPTH];
    logic [AW:0]       wr_ptr [NUM_VC];
    logic [AW:0]       rd_ptr [NUM_VC];

    logic [NUM_VC-1:0] empty, full, hit, push, pop_v;
    logic [VC_W-1:0]   rr_ptr, rr_grant, grant, locked_vc;
    logic              lock, found, pop, vc_ok, ovf_set, parity_ok;

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            empty[v] = (wr_ptr[v] == rd_ptr[v]);
            full[v]  = (wr_ptr[v][AW] != rd_ptr[v][AW]) &&
                       (wr_ptr[v][AW-1:0] == rd_ptr[v][AW-1:0]);
        end
    end

    // Round-robin search over non-empty VCs, starting at rr_ptr.
    always_comb begin
        rr_grant = '0;
        found    = 1'b0;
        for (int i = 0; i < NUM_VC; i++) begin
            int idx;
            idx = (int'(rr_ptr) + i) % NUM_VC;
            if (!found && !empty[idx]) begin
                found    = 1'b1;
                rr_grant = VC_W'(idx);
            end
        end
    end

    // A stalled grant is held so the presented flit cannot change before it is accepted.
    assign grant         = lock ? locked_vc : rr_grant;
    assign sw_data_ready = |(~empty);
    assign sw_vc         = grant;
    assign sw_flit       = mem[grant][rd_ptr[grant][AW-1:0]];
    assign pop           = sw_data_ready && sw_ready;
    assign buffer_full   = full;

`ifdef PHY_RX_PARITY_EN
    assign parity_ok = (parity_in == ^phy_flit);
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        vc_ok   = 1'b0;
        ovf_set = 1'b0;
        hit     = '0;
        push    = '0;
        pop_v   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            pop_v[v] = pop && (grant == VC_W'(v));
            hit[v]   = phy_valid && (phy_vc == VC_W'(v));
            if (hit[v]) vc_ok = 1'b1;
            // A pop on the same VC frees the slot, so a full VC can still accept.
            if (hit[v] && full[v] && !pop_v[v]) ovf_set = 1'b1;
            push[v] = hit[v] && parity_ok && (!full[v] || pop_v[v]);
        end
        if (phy_valid && !vc_ok) ovf_set = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int v = 0; v < NUM_VC; v++) begin
                wr_ptr[v] <= '0;
                rd_ptr[v] <= '0;
            end
            rr_ptr       <= '0;
            lock         <= 1'b0;
            locked_vc    <= '0;
            overflow_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (push[v])  wr_ptr[v] <= wr_ptr[v] + {{AW{1'b0}}, 1'b1};
                if (pop_v[v]) rd_ptr[v] <= rd_ptr[v] + {{AW{1'b0}}, 1'b1};
            end
            if (pop) rr_ptr <= VC_W'((int'(grant) + 1) % NUM_VC);
            lock      <= sw_data_ready && !sw_ready;
            locked_vc <= grant;
            if (ovf_set) overflow_err <= 1'b1;
        end
    end

`ifdef PHY_RX_PARITY_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            parity_err <= 1'b0;
        end else if (phy_valid && !parity_ok) begin
            parity_err <= 1'b1;
        end
    end
`endif

    always_ff @(posedge CLK) begin
        for (int v = 0; v < NUM_VC; v++) begin
            if (push[v]) mem[v][wr_ptr[v][AW-1:0]] <= phy_flit;
        end
    end

endmodule

// File: tb/tb_phy_rx_vc_manager.sv
// Scoreboard bench for phy_rx_vc_manager: directed pushes queue expected flits, a negedge monitor
// compares every accepted output. Parity cases run when PHY_RX_PARITY_EN is defined.
module tb_phy_rx_vc_manager;

    localparam int FLIT_W = 32;
    localparam int NUM_VC = 2;
    localparam int DEPTH  = 4;
    localparam int VC_W   = 1;

    logic              CLK = 1'b0;
    logic              nRST;
    logic              phy_valid;
    logic [FLIT_W-1:0] phy_flit;
    logic [VC_W-1:0]   phy_vc;
    logic [NUM_VC-1:0] buffer_full;
    logic              sw_data_ready;
    logic [FLIT_W-1:0] sw_flit;
    logic [VC_W-1:0]   sw_vc;
    logic              sw_ready;
    logic              overflow_err;
`ifdef PHY_RX_PARITY_EN
    logic              parity_in;
    logic              parity_err;
`endif

    phy_rx_vc_manager #(
        .FLIT_W(FLIT_W),
        .NUM_VC(NUM_VC),
        .DEPTH (DEPTH)
    ) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .phy_valid    (phy_valid),
        .phy_flit     (phy_flit),
        .phy_vc       (phy_vc),
        .buffer_full  (buffer_full),
        .sw_data_ready(sw_data_ready),
        .sw_flit      (sw_flit),
        .sw_vc        (sw_vc),
        .sw_ready     (sw_ready),
        .overflow_err (overflow_err)
`ifdef PHY_RX_PARITY_EN
        ,
        .parity_in    (parity_in),
        .parity_err   (parity_err)
`endif
    );

    always #5 CLK = ~CLK;

    logic [VC_W+FLIT_W-1:0] exp_q [$];
    logic [VC_W+FLIT_W-1:0] mon_exp;
    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    endtask

    // Monitor: every accepted transfer must match the next expected flit.
    always @(negedge CLK) begin
        if (nRST === 1'b1 && sw_data_ready === 1'b1 && sw_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_output: got flit 0x%0h vc %0d, required none",
                         sw_flit, sw_vc);
            end else begin
                mon_exp = exp_q.pop_front();
                check("sw_flit", {32'h0, sw_flit}, {32'h0, mon_exp[FLIT_W-1:0]});
                check("sw_vc", {63'h0, sw_vc}, {63'h0, mon_exp[FLIT_W]});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] flit);
        phy_valid = 1'b1;
        phy_vc    = vc;
        phy_flit  = flit;
`ifdef PHY_RX_PARITY_EN
        parity_in = ^flit;
`endif
        tick();
        phy_valid = 1'b0;
    endtask

    task automatic expect_out(input logic [VC_W-1:0] vc, input logic [FLIT_W-1:0] flit);
        exp_q.push_back({vc, flit});
    endtask

    task automatic drain(input int n);
        sw_ready = 1'b1;
        repeat (n) tick();
        sw_ready = 1'b0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        nRST      = 1'b0;
        phy_valid = 1'b0;
        phy_flit  = '0;
        phy_vc    = '0;
        sw_ready  = 1'b0;
`ifdef PHY_RX_PARITY_EN
        parity_in = 1'b0;
`endif
        tick();
        tick();
        check("rst_ready", {63'h0, sw_data_ready}, 64'h0);
        check("rst_full", {62'h0, buffer_full}, 64'h0);
        check("rst_vc", {63'h0, sw_vc}, 64'h0);
        check("rst_ovf", {63'h0, overflow_err}, 64'h0);
        nRST = 1'b1;
        tick();

        // Single VC fill, overflow, then in-order drain.
        for (int i = 1; i <= 4; i++) begin
            push(1'b0, 32'hA5A5_0000 + 32'(i));
            if (i == 3) check("full_after3", {62'h0, buffer_full}, 64'h0);
        end
        check("full_after4", {62'h0, buffer_full}, 64'h1);
        check("head_vc0", {32'h0, sw_flit}, 64'hA5A5_0001);
        check("ovf_before", {63'h0, overflow_err}, 64'h0);
        push(1'b0, 32'hDEAD_BEEF);
        check("ovf_drop", {63'h0, overflow_err}, 64'h1);
        check("full_still", {62'h0, buffer_full}, 64'h1);
        for (int i = 1; i <= 4; i++) expect_out(1'b0, 32'hA5A5_0000 + 32'(i));
        drain(4);
        check("empty_after_drain", {63'h0, sw_data_ready}, 64'h0);
        check("ovf_sticky", {63'h0, overflow_err}, 64'h1);

        // Full VC with simultaneous pop and push.
        do_reset();
        for (int i = 0; i < 4; i++) push(1'b0, 32'hB000_0000 + 32'(i));
        check("full_fp", {62'h0, buffer_full}, 64'h1);
        expect_out(1'b0, 32'hB000_0000);
        sw_ready  = 1'b1;
        phy_valid = 1'b1;
        phy_vc    = 1'b0;
        phy_flit  = 32'h1234_5678;
        tick();
        sw_ready  = 1'b0;
        phy_valid = 1'b0;
        check("fp_no_ovf", {63'h0, overflow_err}, 64'h0);
        check("fp_full", {62'h0, buffer_full}, 64'h1);
        check("fp_head", {32'h0, sw_flit}, 64'hB000_0001);
        expect_out(1'b0, 32'hB000_0001);
        expect_out(1'b0, 32'hB000_0002);
        expect_out(1'b0, 32'hB000_0003);
        expect_out(1'b0, 32'h1234_5678);
        drain(4);
        check("fp_empty", {63'h0, sw_data_ready}, 64'h0);

        // Round-robin alternation between two VCs.
        do_reset();
        push(1'b0, 32'h10);
        push(1'b0, 32'h11);
        push(1'b1, 32'h20);
        push(1'b1, 32'h21);
        check("rr_full", {62'h0, buffer_full}, 64'h0);
        expect_out(1'b0, 32'h10);
        expect_out(1'b1, 32'h20);
        expect_out(1'b0, 32'h11);
        expect_out(1'b1, 32'h21);
        drain(4);
        check("rr_empty", {63'h0, sw_data_ready}, 64'h0);

        // Stall: VC1 granted first, VC0 fills behind it; grant must hold.
        push(1'b1, 32'h20);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) push(1'b0, 32'h30 + 32'(i));
            else tick();
            check("stall_flit", {32'h0, sw_flit}, 64'h20);
            check("stall_vc", {63'h0, sw_vc}, 64'h1);
        end
        check("stall_full", {62'h0, buffer_full}, 64'h1);
        expect_out(1'b1, 32'h20);
        for (int i = 0; i < 4; i++) expect_out(1'b0, 32'h30 + 32'(i));
        drain(5);
        check("stall_empty", {63'h0, sw_data_ready}, 64'h0);

        // Reset mid-stream discards buffered flits.
        push(1'b0, 32'h50);
        push(1'b0, 32'h51);
        push(1'b1, 32'h52);
        phy_valid = 1'b1;
        phy_vc    = 1'b1;
        phy_flit  = 32'h0;
        tick();
        phy_valid = 1'b0;
        check("mid_ovf_clear", {63'h0, overflow_err}, 64'h0);
        check("mid_ready", {63'h0, sw_data_ready}, 64'h1);
        nRST = 1'b0;
        #1;
        check("mid_rst_ready", {63'h0, sw_data_ready}, 64'h0);
        check("mid_rst_full", {62'h0, buffer_full}, 64'h0);
        check("mid_rst_vc", {63'h0, sw_vc}, 64'h0);
        tick();
        nRST = 1'b1;
        tick();
        check("mid_lost", {63'h0, sw_data_ready}, 64'h0);

`ifdef PHY_RX_PARITY_EN
        phy_valid = 1'b1;
        phy_vc    = 1'b0;
        phy_flit  = 32'h0000_0001;
        parity_in = 1'b0;
        tick();
        phy_valid = 1'b0;
        check("par_err", {63'h0, parity_err}, 64'h1);
        check("par_drop", {63'h0, sw_data_ready}, 64'h0);
        check("par_no_ovf", {63'h0, overflow_err}, 64'h0);
        push(1'b0, 32'h0000_0001);
        check("par_accept", {63'h0, sw_data_ready}, 64'h1);
        check("par_head", {32'h0, sw_flit}, 64'h1);
        expect_out(1'b0, 32'h0000_0001);
        drain(1);
`endif

        tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
